algo_1r1w_req_arb: RTL and testbench

ALGO_1R1W_REQ_ARB -- requirements
Module: algo_1r1w_req_arb

---
 rtl/algo_1r1w_req_arb.sv | 234 +++++++++++++++++++++++
 tb/tb_algo_1r1w_req_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_1r1w_req_arb.sv
// Multi-requester front end for a 1R1W memory: independent round-robin read and
// write arbiters, registered issue to memory, and read-data routing back to the
// requester through a latency-matched tag pipeline.
module algo_1r1w_req_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUMADDR = 8192,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned NUMREQ  = 4,
  parameter int unsigned BITREQ  = 2,
  parameter int unsigned RD_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester side
  input  logic [NUMREQ-1:0]         rq_read_i,
  input  logic [NUMREQ*BITADDR-1:0] rq_rd_adr_i,
  output logic [NUMREQ-1:0]         rq_rd_gnt_o,
  input  logic [NUMREQ-1:0]         rq_write_i,
  input  logic [NUMREQ*BITADDR-1:0] rq_wr_adr_i,
  input  logic [NUMREQ*WIDTH-1:0]   rq_din_i,
  output logic [NUMREQ-1:0]         rq_wr_gnt_o,
  output logic [NUMREQ-1:0]         rq_rd_vld_o,
  output logic [WIDTH-1:0]          rq_rd_dout_o,
  // memory side
  input  logic                      mem_ready_i,
  output logic                      read_o,
  output logic [BITADDR-1:0]        rd_adr_o,
  output logic                      write_o,
  output logic [BITADDR-1:0]        wr_adr_o,
  output logic [WIDTH-1:0]          din_o,
  input  logic                      rd_vld_i,
  input  logic [WIDTH-1:0]          rd_dout_i,
  // status
  output logic                      ready_o,
  output logic                      adr_err_o,
  output logic                      lat_err_o
);

  // Window after reset during which stray returns from pre-reset reads are ignored.
  localparam int unsigned QW = $clog2(RD_LAT + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   run_c;

  logic               rd_hit_c, wr_hit_c;
  logic [BITREQ-1:0]  rd_sel_c, wr_sel_c;
  logic [BITREQ-1:0]  rd_cand_c, wr_cand_c;
  logic               rd_acc_c, wr_acc_c;
  logic               rd_adr_ok_c, wr_adr_ok_c;
  logic [BITADDR-1:0] rd_adr_sel_c, wr_adr_sel_c;
  logic [WIDTH-1:0]   din_sel_c;

  logic [BITREQ-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BITREQ-1:0]  wr_ptr_q, wr_ptr_d;
  logic               read_q, read_d;
  logic [BITADDR-1:0] rd_adr_q, rd_adr_d;
  logic [BITREQ-1:0]  rd_idx_q, rd_idx_d;
  logic               write_q, write_d;
  logic [BITADDR-1:0] wr_adr_q, wr_adr_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               adr_err_q, adr_err_d;
  logic               lat_err_q, lat_err_d;
  logic [QW-1:0]      quiet_q, quiet_d;

  logic [RD_LAT-1:0]              tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][BITREQ-1:0]  tag_idx_q, tag_idx_d;
  logic                           head_vld_c;
  logic [BITREQ-1:0]              head_idx_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: wait for the memory once, then run forever
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (mem_ready_i) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run_c   = (state_q == ST_RUN) && !rst;
  assign ready_o = (state_q == ST_RUN);

  // Read arbiter: first requester at or after the pointer, wrapping
  always_comb begin
    rd_hit_c  = 1'b0;
    rd_sel_c  = '0;
    rd_cand_c = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      rd_cand_c = BITREQ'((32'(rd_ptr_q) + k) % NUMREQ);
      if (!rd_hit_c && rq_read_i[rd_cand_c]) begin
        rd_hit_c = 1'b1;
        rd_sel_c = rd_cand_c;
      end
    end
  end

  // Write arbiter: same policy, independent pointer
  always_comb begin
    wr_hit_c  = 1'b0;
    wr_sel_c  = '0;
    wr_cand_c = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      wr_cand_c = BITREQ'((32'(wr_ptr_q) + k) % NUMREQ);
      if (!wr_hit_c && rq_write_i[wr_cand_c]) begin
        wr_hit_c = 1'b1;
        wr_sel_c = wr_cand_c;
      end
    end
  end

  assign rd_acc_c = run_c && rd_hit_c;
  assign wr_acc_c = run_c && wr_hit_c;

  assign rd_adr_sel_c = rq_rd_adr_i[32'(rd_sel_c)*BITADDR +: BITADDR];
  assign wr_adr_sel_c = rq_wr_adr_i[32'(wr_sel_c)*BITADDR +: BITADDR];
  assign din_sel_c    = rq_din_i[32'(wr_sel_c)*WIDTH +: WIDTH];

  assign rd_adr_ok_c = 32'(rd_adr_sel_c) < NUMADDR;
  assign wr_adr_ok_c = 32'(wr_adr_sel_c) < NUMADDR;

  // One-hot grants, combinational in the request cycle
  always_comb begin
    rq_rd_gnt_o = '0;
    rq_wr_gnt_o = '0;
    if (rd_acc_c) rq_rd_gnt_o[rd_sel_c] = 1'b1;
    if (wr_acc_c) rq_wr_gnt_o[wr_sel_c] = 1'b1;
  end

  // Issue registers, pointers and address error; out-of-range requests are granted but dropped
  always_comb begin
    read_d    = rd_acc_c && rd_adr_ok_c;
    rd_adr_d  = read_d ? rd_adr_sel_c : rd_adr_q;
    rd_idx_d  = read_d ? rd_sel_c : rd_idx_q;
    rd_ptr_d  = rd_acc_c ? BITREQ'((32'(rd_sel_c) + 32'd1) % NUMREQ) : rd_ptr_q;

    write_d   = wr_acc_c && wr_adr_ok_c;
    wr_adr_d  = write_d ? wr_adr_sel_c : wr_adr_q;
    din_d     = write_d ? din_sel_c : din_q;
    wr_ptr_d  = wr_acc_c ? BITREQ'((32'(wr_sel_c) + 32'd1) % NUMREQ) : wr_ptr_q;

    adr_err_d = adr_err_q
              | (rd_acc_c && !rd_adr_ok_c)
              | (wr_acc_c && !wr_adr_ok_c);
  end

  // Tag pipeline: an issued read's requester index arrives at the head with its data
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = read_q;
    tag_idx_d[0] = rd_idx_q;
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  assign head_vld_c = tag_vld_q[RD_LAT-1];
  assign head_idx_c = tag_idx_q[RD_LAT-1];

  // Route returning data to the owning requester
  always_comb begin
    rq_rd_vld_o  = '0;
    rq_rd_dout_o = '0;
    if (!rst && rd_vld_i && head_vld_c) begin
      rq_rd_vld_o[head_idx_c] = 1'b1;
      rq_rd_dout_o            = rd_dout_i;
    end
  end

  // Latency check: memory return and expected tag must coincide
  always_comb begin
    quiet_d   = (quiet_q != '0) ? quiet_q - QW'(1) : '0;
    lat_err_d = lat_err_q
              | (rd_vld_i && !head_vld_c && (quiet_q == '0))
              | (!rd_vld_i && head_vld_c);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      read_q    <= 1'b0;
      rd_adr_q  <= '0;
      rd_idx_q  <= '0;
      write_q   <= 1'b0;
      wr_adr_q  <= '0;
      din_q     <= '0;
      adr_err_q <= 1'b0;
      lat_err_q <= 1'b0;
      quiet_q   <= QW'(RD_LAT);
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      read_q    <= read_d;
      rd_adr_q  <= rd_adr_d;
      rd_idx_q  <= rd_idx_d;
      write_q   <= write_d;
      wr_adr_q  <= wr_adr_d;
      din_q     <= din_d;
      adr_err_q <= adr_err_d;
      lat_err_q <= lat_err_d;
      quiet_q   <= quiet_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  assign read_o    = read_q;
  assign rd_adr_o  = rd_adr_q;
  assign write_o   = write_q;
  assign wr_adr_o  = wr_adr_q;
  assign din_o     = din_q;
  assign adr_err_o = adr_err_q;
  assign lat_err_o = lat_err_q;

endmodule

// File: tb/tb_algo_1r1w_req_arb.sv
// Bench for algo_1r1w_req_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_algo_1r1w_req_arb;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUMADDR = 8192;
  localparam int unsigned BITADDR = 14;
  localparam int unsigned NUMREQ  = 4;
  localparam int unsigned BITREQ  = 2;
  localparam int unsigned RD_LAT  = 4;

  logic                      clk;
  logic                      rst;
  logic [NUMREQ-1:0]         rq_read;
  logic [NUMREQ*BITADDR-1:0] rq_rd_adr;
  logic [NUMREQ-1:0]         rq_rd_gnt;
  logic [NUMREQ-1:0]         rq_write;
  logic [NUMREQ*BITADDR-1:0] rq_wr_adr;
  logic [NUMREQ*WIDTH-1:0]   rq_din;
  logic [NUMREQ-1:0]         rq_wr_gnt;
  logic [NUMREQ-1:0]         rq_rd_vld;
  logic [WIDTH-1:0]          rq_rd_dout;
  logic                      mem_ready;
  logic                      read;
  logic [BITADDR-1:0]        rd_adr;
  logic                      write;
  logic [BITADDR-1:0]        wr_adr;
  logic [WIDTH-1:0]          din;
  logic                      rd_vld;
  logic [WIDTH-1:0]          rd_dout;
  logic                      ready;
  logic                      adr_err;
  logic                      lat_err;

  algo_1r1w_req_arb #(
    .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR),
    .NUMREQ(NUMREQ), .BITREQ(BITREQ), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .rq_read_i(rq_read), .rq_rd_adr_i(rq_rd_adr), .rq_rd_gnt_o(rq_rd_gnt),
    .rq_write_i(rq_write), .rq_wr_adr_i(rq_wr_adr), .rq_din_i(rq_din),
    .rq_wr_gnt_o(rq_wr_gnt), .rq_rd_vld_o(rq_rd_vld), .rq_rd_dout_o(rq_rd_dout),
    .mem_ready_i(mem_ready), .read_o(read), .rd_adr_o(rd_adr),
    .write_o(write), .wr_adr_o(wr_adr), .din_o(din),
    .rd_vld_i(rd_vld), .rd_dout_i(rd_dout),
    .ready_o(ready), .adr_err_o(adr_err), .lat_err_o(lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus staging, applied just after each rising edge
  bit              s_rst, s_mem_ready, s_inject;
  bit [3:0]        s_read, s_write;
  int unsigned     s_rd_adr [NUMREQ];
  int unsigned     s_wr_adr [NUMREQ];
  logic [31:0]     s_din    [NUMREQ];

  // reference model state
  bit          m_run;
  int          m_rptr, m_wptr;
  bit          m_read, m_write;
  int unsigned m_rd_adr, m_wr_adr;
  logic [31:0] m_din;
  bit          m_adr_err, m_lat_err;
  int          m_rst_end;
  int          exp_ret [int];        // cycle -> requester expecting data
  logic [31:0] mem_sched [int];      // cycle -> data the memory returns

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // round-robin choice: first requesting index from ptr upward with wrap, -1 if none
  function automatic int rr_pick(input bit [3:0] req, input int ptr);
    for (int k = 0; k < int'(NUMREQ); k++) begin
      int i;
      i = (ptr + k) % int'(NUMREQ);
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_reqs();
    s_read = '0;
    s_write = '0;
    s_inject = 1'b0;
  endtask

  task automatic step(input bit do_chk);
    int ri, wi;
    logic [63:0] exp_rg, exp_wg, exp_v, exp_d;
    bit has_ret;
    @(posedge clk);
    cyc++;
    #1;
    rst       = s_rst;
    mem_ready = s_mem_ready;
    rq_read   = s_read;
    rq_write  = s_write;
    for (int i = 0; i < int'(NUMREQ); i++) begin
      rq_rd_adr[i*BITADDR +: BITADDR] = BITADDR'(s_rd_adr[i]);
      rq_wr_adr[i*BITADDR +: BITADDR] = BITADDR'(s_wr_adr[i]);
      rq_din[i*WIDTH +: WIDTH]        = s_din[i];
    end
    if (mem_sched.exists(cyc)) begin
      rd_vld  = 1'b1;
      rd_dout = mem_sched[cyc];
    end else begin
      rd_vld  = s_inject;
      rd_dout = s_inject ? 32'($urandom()) : '0;
    end
    @(negedge clk);

    ri = rr_pick(s_read, m_rptr);
    wi = rr_pick(s_write, m_wptr);
    has_ret = exp_ret.exists(cyc);
    if (do_chk) begin
      exp_rg = (!s_rst && m_run && ri >= 0) ? 64'(1) << ri : 64'(0);
      exp_wg = (!s_rst && m_run && wi >= 0) ? 64'(1) << wi : 64'(0);
      if (!s_rst && rd_vld && has_ret) begin
        exp_v = 64'(1) << exp_ret[cyc];
        exp_d = 64'(rd_dout);
      end else begin
        exp_v = 0;
        exp_d = 0;
      end
      check_eq("ready", 64'(ready), 64'(m_run));
      check_eq("rd_gnt", 64'(rq_rd_gnt), exp_rg);
      check_eq("wr_gnt", 64'(rq_wr_gnt), exp_wg);
      check_eq("read", 64'(read), 64'(m_read));
      if (m_read) check_eq("rd_adr", 64'(rd_adr), 64'(m_rd_adr));
      check_eq("write", 64'(write), 64'(m_write));
      if (m_write) begin
        check_eq("wr_adr", 64'(wr_adr), 64'(m_wr_adr));
        check_eq("din", 64'(din), 64'(m_din));
      end
      check_eq("rq_rd_vld", 64'(rq_rd_vld), exp_v);
      check_eq("rq_rd_dout", 64'(rq_rd_dout), exp_d);
      check_eq("adr_err", 64'(adr_err), 64'(m_adr_err));
      check_eq("lat_err", 64'(lat_err), 64'(m_lat_err));
    end

    // memory environment: every read the memory sees comes back RD_LAT later
    if (read === 1'b1) mem_sched[cyc + int'(RD_LAT)] = 32'($urandom());
    if (mem_sched.exists(cyc)) mem_sched.delete(cyc);

    if (s_rst) begin
      m_run = 0; m_rptr = 0; m_wptr = 0;
      m_read = 0; m_write = 0;
      m_adr_err = 0; m_lat_err = 0;
      exp_ret.delete();
      m_rst_end = cyc + 1;
    end else begin
      if (rd_vld && !has_ret && (cyc - m_rst_end >= int'(RD_LAT))) m_lat_err = 1;
      if (!rd_vld && has_ret) m_lat_err = 1;
      if (has_ret) exp_ret.delete(cyc);
      m_read = 0;
      m_write = 0;
      if (m_run) begin
        if (ri >= 0) begin
          m_rptr = (ri + 1) % int'(NUMREQ);
          if (s_rd_adr[ri] < NUMADDR) begin
            m_read = 1;
            m_rd_adr = s_rd_adr[ri];
            exp_ret[cyc + 1 + int'(RD_LAT)] = ri;
          end else m_adr_err = 1;
        end
        if (wi >= 0) begin
          m_wptr = (wi + 1) % int'(NUMREQ);
          if (s_wr_adr[wi] < NUMADDR) begin
            m_write = 1;
            m_wr_adr = s_wr_adr[wi];
            m_din = s_din[wi];
          end else m_adr_err = 1;
        end
      end else if (s_mem_ready) begin
        m_run = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; rq_read = '0; rq_write = '0;
    rq_rd_adr = '0; rq_wr_adr = '0; rq_din = '0; rd_vld = 1'b0; rd_dout = '0;
    for (int i = 0; i < int'(NUMREQ); i++) begin
      s_rd_adr[i] = 16 * i; s_wr_adr[i] = 16 * i + 1; s_din[i] = 32'($urandom());
    end
    clear_reqs();
    s_rst = 1'b1; s_mem_ready = 1'b0;
    step(0);
    step(0);
    s_rst = 1'b0;

    // memory not ready: nothing granted
    s_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check_eq("init_gnt", 64'(rq_rd_gnt), 64'(0));
      check_eq("init_ready", 64'(ready), 64'(0));
    end
    check_eq("rst_rd_adr", 64'(rd_adr), 64'(0));
    s_mem_ready = 1'b1;
    step(1);
    check_eq("init_edge_gnt", 64'(rq_rd_gnt), 64'(0));

    // round-robin over four constant requesters
    for (int k = 0; k < 8; k++) begin
      step(1);
      check_eq("rr_gnt", 64'(rq_rd_gnt), 64'(1) << (k % 4));
      check_eq("rr_ready", 64'(ready), 64'(1));
    end
    clear_reqs();
    repeat (6) step(1);

    // single read and its return
    s_read = 4'b0100; s_rd_adr[2] = 32'h0A5;
    step(1);
    check_eq("ret_gnt", 64'(rq_rd_gnt), 64'(4'b0100));
    clear_reqs();
    step(1);
    check_eq("ret_issue", 64'(read), 64'(1));
    check_eq("ret_adr", 64'(rd_adr), 64'(32'h0A5));
    repeat (3) step(1);
    step(1);
    check_eq("ret_vld", 64'(rq_rd_vld), 64'(4'b0100));
    check_eq("ret_dout", 64'(rq_rd_dout), 64'(rd_dout));
    repeat (3) step(1);

    // simultaneous read and write to the same address
    s_write = 4'b0010; s_wr_adr[1] = 32'h10; s_din[1] = 32'hCAFE_0010;
    s_read  = 4'b1000; s_rd_adr[3] = 32'h10;
    step(1);
    check_eq("rw_rd_gnt", 64'(rq_rd_gnt), 64'(4'b1000));
    check_eq("rw_wr_gnt", 64'(rq_wr_gnt), 64'(4'b0010));
    clear_reqs();
    step(1);
    check_eq("rw_read", 64'(read), 64'(1));
    check_eq("rw_write", 64'(write), 64'(1));
    check_eq("rw_rd_adr", 64'(rd_adr), 64'(32'h10));
    check_eq("rw_wr_adr", 64'(wr_adr), 64'(32'h10));
    check_eq("rw_din", 64'(din), 64'(32'hCAFE_0010));
    repeat (6) step(1);

    // out-of-range read is granted but dropped
    s_read = 4'b0001; s_rd_adr[0] = NUMADDR;
    step(1);
    check_eq("bad_gnt", 64'(rq_rd_gnt), 64'(4'b0001));
    clear_reqs();
    step(1);
    check_eq("bad_read", 64'(read), 64'(0));
    check_eq("bad_adr_err", 64'(adr_err), 64'(1));
    repeat (6) step(1);

    // unsolicited memory return
    s_inject = 1'b1;
    step(1);
    check_eq("unsol_vld", 64'(rq_rd_vld), 64'(0));
    s_inject = 1'b0;
    step(1);
    check_eq("unsol_lat_err", 64'(lat_err), 64'(1));

    // reset with three reads outstanding
    for (int i = 0; i < int'(NUMREQ); i++) s_rd_adr[i] = 32'h100 + i;
    s_read = 4'b1111;
    repeat (3) step(1);
    clear_reqs();
    s_rst = 1'b1;
    step(1);
    s_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check_eq("midrst_vld", 64'(rq_rd_vld), 64'(0));
    end
    check_eq("midrst_lat_err", 64'(lat_err), 64'(0));

    // randomized traffic with occasional resets, stray returns and bad addresses
    for (int n = 0; n < 800; n++) begin
      s_rst       = ($urandom_range(0, 99) == 0);
      s_mem_ready = ($urandom_range(0, 3) != 0);
      s_inject    = ($urandom_range(0, 59) == 0);
      s_read      = 4'($urandom());
      s_write     = 4'($urandom());
      for (int i = 0; i < int'(NUMREQ); i++) begin
        s_rd_adr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(8192, 16383) : $urandom_range(0, 8191);
        s_wr_adr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(8192, 16383) : $urandom_range(0, 8191);
        s_din[i]    = 32'($urandom());
      end
      step(1);
    end
    clear_reqs();
    s_rst = 1'b0;
    repeat (8) step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
